// File: rtl/rf_mp_sb.sv
// ============================================================================
// Module   : rf_mp_sb
// Brief    : Two-write-port register file with per-register pending scoreboard,
//            two combinational read ports with busy flags and a debug tap.
//            Optional write-to-read bypass enabled by defining RF_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_mp_sb #(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1
) (
    input  logic          clk,
    input  logic          clr,
    input  logic [AW-1:0] ra,
    input  logic [AW-1:0] rb,
    output logic [DW-1:0] qa,
    output logic [DW-1:0] qb,
    output logic          qa_busy,
    output logic          qb_busy,
    input  logic          we0,
    input  logic [AW-1:0] rw0,
    input  logic [DW-1:0] wd0,
    input  logic          we1,
    input  logic [AW-1:0] rw1,
    input  logic [DW-1:0] wd1,
    input  logic          iss_en,
    input  logic [AW-1:0] iss_rd,
    output logic [AW:0]   pend_cnt,
    input  logic [AW-1:0] dbg_addr,
    output logic [DW-1:0] dbg_data
);

    localparam int DEPTH = 1 << AW;
    localparam bit ZR    = (ZERO_REG != 0);

    logic [DW-1:0]    mem_q [DEPTH];
    logic [DEPTH-1:0] pend_q;
    logic [DEPTH-1:0] pend_d;
    logic [AW:0]      pend_cnt_q;
    logic [AW:0]      pend_cnt_d;

    logic we0_eff;
    logic we1_eff;
    logic iss_eff;

    function automatic logic is_zero_reg(input logic [AW-1:0] a);
        return ZR && (a == '0);
    endfunction

    assign we0_eff = we0 && !is_zero_reg(rw0);
    assign we1_eff = we1 && !is_zero_reg(rw1);
    assign iss_eff = iss_en && !is_zero_reg(iss_rd);

    // Issue is applied after the clears so a new producer supersedes a write.
    always_comb begin
        pend_d = pend_q;
        if (we0_eff) pend_d[rw0] = 1'b0;
        if (we1_eff) pend_d[rw1] = 1'b0;
        if (iss_eff) pend_d[iss_rd] = 1'b1;
        pend_cnt_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            pend_cnt_d = pend_cnt_d + (AW+1)'(pend_d[i]);
        end
    end

    // Port 1 is written last so it wins an address collision.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            pend_q     <= '0;
            pend_cnt_q <= '0;
        end else begin
            if (we0_eff) mem_q[rw0] <= wd0;
            if (we1_eff) mem_q[rw1] <= wd1;
            pend_q     <= pend_d;
            pend_cnt_q <= pend_cnt_d;
        end
    end

    // Returns {busy, data} for one read port.
    function automatic logic [DW:0] read_port(input logic [AW-1:0] a);
        logic [DW-1:0] d;
        logic          b;
        d = mem_q[a];
        b = pend_q[a];
`ifdef RF_BYPASS_EN
        if (we1_eff && (rw1 == a)) begin
            d = wd1;
        end else if (we0_eff && (rw0 == a)) begin
            d = wd0;
        end
        if (((we1_eff && (rw1 == a)) || (we0_eff && (rw0 == a)))
            && !(iss_en && (iss_rd == a))) begin
            b = 1'b0;
        end
`endif
        if (is_zero_reg(a)) begin
            d = '0;
            b = 1'b0;
        end
        return {b, d};
    endfunction

    logic [DW:0] rd_a;
    logic [DW:0] rd_b;

    assign rd_a     = read_port(ra);
    assign rd_b     = read_port(rb);
    assign qa       = rd_a[DW-1:0];
    assign qa_busy  = rd_a[DW];
    assign qb       = rd_b[DW-1:0];
    assign qb_busy  = rd_b[DW];
    assign pend_cnt = pend_cnt_q;
    assign dbg_data = mem_q[dbg_addr];

endmodule

`default_nettype wire
